// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector
// Takes the registered serial stream from the upstream flip-flop stage, shifts
// qualified bits into a window and flags every occurrence of PATTERN with a
// one-cycle registered pulse. A saturating counter keeps the number of hits.
// OVERLAP selects whether the bits of one hit may be reused by the next hit
// or whether the window has to refill with fresh bits after each hit.

module serial_pattern_detector #(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 4'b1011,
  parameter int                       COUNT_WIDTH   = 8,
  parameter bit                       OVERLAP       = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic                     clear,
  output logic                     match,
  output logic [COUNT_WIDTH-1:0]   match_count,
  output logic                     count_sat,
  output logic [PATTERN_WIDTH-1:0] window
);

  // Wide enough to hold PATTERN_WIDTH itself, not just PATTERN_WIDTH-1.
  localparam int FILL_WIDTH = $clog2(PATTERN_WIDTH + 1);

  // EMPTY: nothing received yet; FILLING: partially loaded window;
  // ARMED: window holds PATTERN_WIDTH genuine bits and can be compared.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } fillState_e;

  fillState_e               state_q, state_d;
  logic [FILL_WIDTH-1:0]    fillCnt_q, fillCnt_d;
  logic [PATTERN_WIDTH-1:0] window_q, window_d;
  logic                     match_q, match_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     sat_q, sat_d;

  logic [PATTERN_WIDTH-1:0] shifted;
  logic [FILL_WIDTH-1:0]    fillCntInc;
  logic                     hit;

  // State register; reset is synchronous and active-low and beats everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= EMPTY;
      fillCnt_q <= '0;
      window_q  <= '0;
      match_q   <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fillCnt_q <= fillCnt_d;
      window_q  <= window_d;
      match_q   <= match_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  // Next-state logic: clear wins over a valid bit, idle edges hold everything
  // except the match pulse, which only ever lasts one cycle.
  always_comb begin
    state_d    = state_q;
    fillCnt_d  = fillCnt_q;
    window_d   = window_q;
    match_d    = 1'b0;
    count_d    = count_q;
    sat_d      = sat_q;
    shifted    = {window_q[PATTERN_WIDTH-2:0], din};
    fillCntInc = fillCnt_q + FILL_WIDTH'(1);
    hit        = 1'b0;

    if (clear) begin
      state_d   = EMPTY;
      fillCnt_d = '0;
      window_d  = '0;
      count_d   = '0;
      sat_d     = 1'b0;
    end else if (din_valid) begin
      window_d = shifted;

      case (state_q)
        EMPTY: begin
          state_d   = FILLING;
          fillCnt_d = FILL_WIDTH'(1);
        end
        FILLING: begin
          fillCnt_d = fillCntInc;
          if (fillCntInc == FILL_WIDTH'(PATTERN_WIDTH)) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          state_d = ARMED;
        end
        default: begin
          state_d   = EMPTY;
          fillCnt_d = '0;
        end
      endcase

      // Compare against the window as it will be after this bit, and only
      // once the window is fully populated with received bits.
      hit = (state_d == ARMED) && (shifted == PATTERN);

      if (hit) begin
        match_d = 1'b1;
        if (count_q != {COUNT_WIDTH{1'b1}}) begin
          count_d = count_q + COUNT_WIDTH'(1);
        end
        if (count_d == {COUNT_WIDTH{1'b1}}) begin
          sat_d = 1'b1;
        end
        // Without overlap only the fill tracking restarts; the window keeps
        // its contents, but it cannot match again until refilled.
        if (!OVERLAP) begin
          state_d   = EMPTY;
          fillCnt_d = '0;
        end
      end
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign count_sat   = sat_q;
  assign window      = window_q;

endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
- Consumes the registered serial bit stream produced by the DFlipFlop stage (its Q output drives din here).
- Shifts qualified bits into a window and detects a parameterised bit pattern, with overlapping or non-overlapping detection.
- Reports each detection as a one-cycle pulse and keeps a saturating count of detections.
- Sits directly downstream of the flip-flop stage, on the same clock.

Parameters:
- PATTERN_WIDTH, 4: number of bits in the pattern and the window (legal range 2..16).
- PATTERN, 4'b1011: target pattern. MSB is the oldest bit received; LSB is the newest.
- COUNT_WIDTH, 8: width of the match counter.
- OVERLAP, 1: 1 = bits of one match may be reused by the next; 0 = window refills from empty after each match.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- din  input  1  serial data bit (from the DFlipFlop Q).
- din_valid  input  1  din is taken on this edge only when din_valid is 1.
- clear  input  1  synchronous clear of the window, fill state, counter and saturation flag.
- match  output  1  one-cycle pulse, registered.
- match_count  output  COUNT_WIDTH  number of matches since reset/clear; saturating.
- count_sat  output  1  sticky; 1 once match_count has reached its all-ones value.
- window  output  PATTERN_WIDTH  current shift-register contents (newest bit at LSB).

Behaviour:
- Interface is fixed: one clock, clk. reset is synchronous and active-low.
- Edge priority: reset low > clear high > din_valid high > hold.
- Reset (reset==0 at an edge): window=0, fill state EMPTY, match=0, match_count=0, count_sat=0. Applies even with din_valid or clear high on the same edge; that bit is discarded.
- clear (reset high, clear==1): same zeroing as reset. The din presented on that edge is dropped.
- Fill state machine, tracking bits received since reset/clear/non-overlap restart:
  - EMPTY -> FILLING on the first valid bit (-> ARMED directly if PATTERN_WIDTH==1 is ever allowed; not legal here).
  - FILLING -> ARMED when the PATTERN_WIDTH-th valid bit is taken.
  - ARMED holds while OVERLAP=1.
  - With OVERLAP=0, a match forces the next state to EMPTY.
- Valid edge (din_valid==1): window_next = {window[PATTERN_WIDTH-2:0], din}.
- Match condition: the next fill state is ARMED (before any OVERLAP=0 restart) and window_next == PATTERN. When true, match=1 for exactly the following cycle (1-cycle latency from the edge taking the completing bit).
- match_count: increments by 1 with each match unless already all-ones. When it reaches all-ones, count_sat is set on the same edge. count_sat stays set until reset/clear; the count never wraps.
- Idle edge (din_valid==0): window, fill state, count and count_sat hold; match=0.
  - Gaps in din_valid do not break a partially received pattern.
- Matches cannot occur on consecutive valid edges unless PATTERN permits it under OVERLAP=1; no special-casing is allowed.
- With OVERLAP=0, window contents are not zeroed on a match, only the fill state, so a new match needs PATTERN_WIDTH fresh bits.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Overlap: defaults; after reset, apply din_valid=1 with din=1,0,1,1,0,1,1 on consecutive edges -> match pulses the cycle after bits 4 and 7; match_count=2; window=4'b1011.
- No overlap: OVERLAP=0, same stream -> single match after bit 4; match_count=1; fill state FILLING (3 bits) at end.
- Free-running DFlipFlop source: clk period 10, din toggling every 10 ns, din_valid=1 for 40 edges -> alternating 0101 stream never equals 1011; match never asserted; match_count=0.
- Saturation: COUNT_WIDTH=2, send 1011 five times with gaps -> match_count goes 1,2,3,3,3; count_sat=1 from the 3rd match; match still pulses on matches 4 and 5.
- Clear and gaps: send 1,0,1 with idle cycles between bits, then assert clear alongside din=1, then send 1 -> no match; window=4'b0001; match_count=0.
- Reset mid-operation: after 2 matches, hold reset=0 for one edge with din_valid=1, din=1 -> next cycle all outputs 0. A full 1011 must then be re-received before the next match.
